// File: rtl/cflow_log_writer.sv
// Control-flow log writer: packs src/dest(/repeat count) entries into the CFLog
// one 16-bit word per cycle and requests TCB flushes on watermark or ER exit.
module cflow_log_writer #(
  parameter int unsigned LOG_SIZE      = 32'h0000_0080,
  parameter int unsigned PTR_W         = 16,
  parameter int unsigned LOOP_COMPRESS = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             branch_detect,
  input  logic [15:0]      cflow_src,
  input  logic [15:0]      cflow_dest,
  input  logic             ER_done,
  input  logic             flush_ack,
  output logic             log_wen,
  output logic [PTR_W-1:0] log_ptr,
  output logic [15:0]      log_data,
  output logic             flush,
  output logic             overrun
);

  localparam bit          COMPRESS = (LOOP_COMPRESS != 0);
  localparam int unsigned ENTRY_W  = COMPRESS ? 3 : 2;

  typedef enum logic [2:0] {
    IDLE, W_SRC, W_DST, W_CNT, FLUSH, FLUSH_WAIT
  } state_e;

  localparam state_e LAST_WR = COMPRESS ? W_CNT : W_DST;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               pend_valid_q, pend_valid_d;
  logic [15:0]        pend_src_q, pend_src_d, pend_dst_q, pend_dst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               com_valid_q, com_valid_d;
  logic [15:0]        com_src_q, com_src_d, com_dst_q, com_dst_d;
  logic [CNT_W-1:0]   com_cnt_q, com_cnt_d;
  logic               er_req_q, er_req_d;
  logic               overrun_q, overrun_d;
  logic               log_wen_q, log_wen_d;
  logic [PTR_W-1:0]   log_ptr_q, log_ptr_d;
  logic [15:0]        log_data_q, log_data_d;
  logic               flush_q, flush_d;
  logic               com_free_c, er_any_c, same_pair_c, fits_c;

  assign log_wen  = log_wen_q;
  assign log_ptr  = log_ptr_q;
  assign log_data = log_data_q;
  assign flush    = flush_q;
  assign overrun  = overrun_q;

  // Event capture, next-state decode and next-cycle output values
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pend_valid_d = pend_valid_q;
    pend_src_d   = pend_src_q;
    pend_dst_d   = pend_dst_q;
    cnt_d        = cnt_q;
    com_valid_d  = com_valid_q;
    com_src_d    = com_src_q;
    com_dst_d    = com_dst_q;
    com_cnt_d    = com_cnt_q;
    er_req_d     = er_req_q | ER_done;
    overrun_d    = overrun_q;
    log_wen_d    = 1'b0;
    log_ptr_d    = '0;
    log_data_d   = '0;
    flush_d      = 1'b0;

    // Commit slot is released while its last word is being written
    com_free_c  = !com_valid_q || (state_q == LAST_WR);
    er_any_c    = er_req_q | ER_done;
    same_pair_c = (cflow_src == pend_src_q) && (cflow_dest == pend_dst_q);
    fits_c      = (32'(ptr_q) + ENTRY_W) <= LOG_SIZE;

    if (state_q == LAST_WR) com_valid_d = 1'b0;

    if (COMPRESS) begin
      if (branch_detect) begin
        if (pend_valid_q && same_pair_c && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_src_d   = cflow_src;
          pend_dst_d   = cflow_dest;
          cnt_d        = CNT_W'(1);
        end else if (com_free_c) begin
          com_valid_d = 1'b1;
          com_src_d   = pend_src_q;
          com_dst_d   = pend_dst_q;
          com_cnt_d   = cnt_q;
          pend_src_d  = cflow_src;
          pend_dst_d  = cflow_dest;
          cnt_d       = CNT_W'(1);
        end else begin
          overrun_d = 1'b1;
        end
      end else if (er_any_c && pend_valid_q && com_free_c) begin
        com_valid_d  = 1'b1;
        com_src_d    = pend_src_q;
        com_dst_d    = pend_dst_q;
        com_cnt_d    = cnt_q;
        pend_valid_d = 1'b0;
      end
    end else if (branch_detect) begin
      if (com_free_c) begin
        com_valid_d = 1'b1;
        com_src_d   = cflow_src;
        com_dst_d   = cflow_dest;
        com_cnt_d   = CNT_W'(1);
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (com_valid_q)                                    state_d = fits_c ? W_SRC : FLUSH;
        else if (er_req_q && !(COMPRESS && pend_valid_q))   state_d = FLUSH;
      end
      W_SRC: state_d = W_DST;
      W_DST: state_d = COMPRESS ? W_CNT : IDLE;
      W_CNT: state_d = IDLE;
      FLUSH: begin
        state_d = FLUSH_WAIT;
        flush_d = 1'b1;
      end
      FLUSH_WAIT: begin
        if (flush_ack) begin
          state_d  = IDLE;
          ptr_d    = '0;
          er_req_d = ER_done;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Write strobes are registered alongside the state they belong to
    case (state_d)
      W_SRC: begin
        log_wen_d  = 1'b1;
        log_ptr_d  = ptr_q;
        log_data_d = com_src_q;
        ptr_d      = ptr_q + PTR_W'(1);
      end
      W_DST: begin
        log_wen_d  = 1'b1;
        log_ptr_d  = ptr_q;
        log_data_d = com_dst_q;
        ptr_d      = ptr_q + PTR_W'(1);
      end
      W_CNT: begin
        log_wen_d  = 1'b1;
        log_ptr_d  = ptr_q;
        log_data_d = 16'(com_cnt_q);
        ptr_d      = ptr_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_src_q   <= '0;
      pend_dst_q   <= '0;
      cnt_q        <= '0;
      com_valid_q  <= 1'b0;
      com_src_q    <= '0;
      com_dst_q    <= '0;
      com_cnt_q    <= '0;
      er_req_q     <= 1'b0;
      overrun_q    <= 1'b0;
      log_wen_q    <= 1'b0;
      log_ptr_q    <= '0;
      log_data_q   <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_src_q   <= pend_src_d;
      pend_dst_q   <= pend_dst_d;
      cnt_q        <= cnt_d;
      com_valid_q  <= com_valid_d;
      com_src_q    <= com_src_d;
      com_dst_q    <= com_dst_d;
      com_cnt_q    <= com_cnt_d;
      er_req_q     <= er_req_d;
      overrun_q    <= overrun_d;
      log_wen_q    <= log_wen_d;
      log_ptr_q    <= log_ptr_d;
      log_data_q   <= log_data_d;
      flush_q      <= flush_d;
    end
  end

endmodule

// File: tb/tb_cflow_log_writer.sv
// Directed bench for cflow_log_writer: four parameter variants share stimulus,
// each test checks the variant it targets against hand-computed log contents.
module tb_cflow_log_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        branch_detect;
  logic [15:0] cflow_src, cflow_dest;
  logic        ER_done, flush_ack;

  logic        wen  [4];
  logic [15:0] ptr  [4];
  logic [15:0] data [4];
  logic        flsh [4];
  logic        ovr  [4];

  logic [31:0] wlog [4][16];
  int          wcnt [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 0: plain, 1: compress, 2: compress CNT_W=2, 3: compress LOG_SIZE=6
  cflow_log_writer #(.LOOP_COMPRESS(0)) u_plain (
    .clk(clk), .reset_n(reset_n), .branch_detect(branch_detect), .cflow_src(cflow_src),
    .cflow_dest(cflow_dest), .ER_done(ER_done), .flush_ack(flush_ack), .log_wen(wen[0]),
    .log_ptr(ptr[0]), .log_data(data[0]), .flush(flsh[0]), .overrun(ovr[0]));
  cflow_log_writer #(.LOOP_COMPRESS(1)) u_cmp (
    .clk(clk), .reset_n(reset_n), .branch_detect(branch_detect), .cflow_src(cflow_src),
    .cflow_dest(cflow_dest), .ER_done(ER_done), .flush_ack(flush_ack), .log_wen(wen[1]),
    .log_ptr(ptr[1]), .log_data(data[1]), .flush(flsh[1]), .overrun(ovr[1]));
  cflow_log_writer #(.LOOP_COMPRESS(1), .CNT_W(2)) u_cnt2 (
    .clk(clk), .reset_n(reset_n), .branch_detect(branch_detect), .cflow_src(cflow_src),
    .cflow_dest(cflow_dest), .ER_done(ER_done), .flush_ack(flush_ack), .log_wen(wen[2]),
    .log_ptr(ptr[2]), .log_data(data[2]), .flush(flsh[2]), .overrun(ovr[2]));
  cflow_log_writer #(.LOOP_COMPRESS(1), .LOG_SIZE(6)) u_ls6 (
    .clk(clk), .reset_n(reset_n), .branch_detect(branch_detect), .cflow_src(cflow_src),
    .cflow_dest(cflow_dest), .ER_done(ER_done), .flush_ack(flush_ack), .log_wen(wen[3]),
    .log_ptr(ptr[3]), .log_data(data[3]), .flush(flsh[3]), .overrun(ovr[3]));

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n) begin
        wcnt[i] <= 0;
      end else if (wen[i]) begin
        if (wcnt[i] < 16) wlog[i][wcnt[i]] <= {ptr[i], data[i]};
        wcnt[i] <= wcnt[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    branch_detect = 1'b0; ER_done = 1'b0; flush_ack = 1'b0;
    cflow_src = '0; cflow_dest = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
  endtask

  // One-cycle event pulse, optionally with ER_done in the same cycle
  task automatic ev(input logic [15:0] s, input logic [15:0] d, input logic er);
    branch_detect = 1'b1; cflow_src = s; cflow_dest = d; ER_done = er;
    tick(1);
    branch_detect = 1'b0; ER_done = 1'b0;
  endtask

  task automatic er_pulse();
    ER_done = 1'b1;
    tick(1);
    ER_done = 1'b0;
  endtask

  task automatic ack_pulse();
    flush_ack = 1'b1;
    tick(1);
    flush_ack = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_wen",   32'(wen[1]),  32'h0);
    check("rst_ptr",   32'(ptr[1]),  32'h0);
    check("rst_data",  32'(data[1]), 32'h0);
    check("rst_flush", 32'(flsh[1]), 32'h0);
    check("rst_ovr",   32'(ovr[1]),  32'h0);

    // Plain mode, two events four cycles apart
    ev(16'hE000, 16'hE010, 1'b0);
    tick(3);
    ev(16'hE020, 16'hE030, 1'b0);
    tick(6);
    check("plain_cnt", 32'(wcnt[0]), 32'd4);
    check("plain_w0",  wlog[0][0], 32'h0000_E000);
    check("plain_w1",  wlog[0][1], 32'h0001_E010);
    check("plain_w2",  wlog[0][2], 32'h0002_E020);
    check("plain_w3",  wlog[0][3], 32'h0003_E030);
    check("plain_ovr", 32'(ovr[0]), 32'h0);

    // Compress mode, 5 repeats then a new pair
    do_reset();
    for (int i = 0; i < 5; i++) ev(16'hE100, 16'hE0F0, 1'b0);
    check("cmp_nowr", 32'(wcnt[1]), 32'd0);
    ev(16'hE200, 16'hE300, 1'b0);
    tick(6);
    check("cmp_cnt", 32'(wcnt[1]), 32'd3);
    check("cmp_w0",  wlog[1][0], 32'h0000_E100);
    check("cmp_w1",  wlog[1][1], 32'h0001_E0F0);
    check("cmp_w2",  wlog[1][2], 32'h0002_0005);
    tick(5);
    check("cmp_pend_held", 32'(wcnt[1]), 32'd3);

    // CNT_W=2 saturation, then new pending flushed out by ER with count 1
    do_reset();
    for (int i = 0; i < 4; i++) ev(16'hE400, 16'hE500, 1'b0);
    tick(6);
    check("sat_cnt", 32'(wcnt[2]), 32'd3);
    check("sat_w0",  wlog[2][0], 32'h0000_E400);
    check("sat_w2",  wlog[2][2], 32'h0002_0003);
    ev(16'hE600, 16'hE700, 1'b0);
    tick(6);
    er_pulse();
    tick(10);
    check("sat_cnt2", 32'(wcnt[2]), 32'd9);
    check("sat_w5",   wlog[2][5], 32'h0005_0001);
    check("sat_w6",   wlog[2][6], 32'h0006_E600);
    check("sat_w8",   wlog[2][8], 32'h0008_0001);
    check("sat_ovr",  32'(ovr[2]), 32'h0);

    // LOG_SIZE=6 watermark
    do_reset();
    ev(16'hA000, 16'hA001, 1'b0); tick(4);
    ev(16'hB000, 16'hB001, 1'b0); tick(4);
    ev(16'hC000, 16'hC001, 1'b0); tick(4);
    ev(16'hD000, 16'hD001, 1'b0);
    tick(6);
    check("wm_cnt",   32'(wcnt[3]), 32'd6);
    check("wm_w5",    wlog[3][5], 32'h0005_0001);
    check("wm_flush", 32'(flsh[3]), 32'h1);
    tick(5);
    check("wm_hold",  32'(wcnt[3]), 32'd6);
    ack_pulse();
    tick(6);
    check("wm_unflush", 32'(flsh[3]), 32'h0);
    check("wm_cnt2",    32'(wcnt[3]), 32'd9);
    check("wm_w6",      wlog[3][6], 32'h0000_C000);
    check("wm_w7",      wlog[3][7], 32'h0001_C001);
    check("wm_w8",      wlog[3][8], 32'h0002_0001);

    // Overrun: three distinct back-to-back events
    do_reset();
    ev(16'hF100, 16'hF101, 1'b0);
    ev(16'hF200, 16'hF201, 1'b0);
    ev(16'hF300, 16'hF301, 1'b0);
    check("ovr_set", 32'(ovr[1]), 32'h1);
    tick(10);
    check("ovr_sticky", 32'(ovr[1]), 32'h1);
    check("ovr_cnt",    32'(wcnt[1]), 32'd3);
    check("ovr_w0",     wlog[1][0], 32'h0000_F100);

    // ER with nothing logged
    do_reset();
    er_pulse();
    tick(4);
    check("er_empty_flush", 32'(flsh[1]), 32'h1);
    check("er_empty_nowr",  32'(wcnt[1]), 32'd0);
    ack_pulse();
    tick(2);
    check("er_empty_unflush", 32'(flsh[1]), 32'h0);

    // ER with one pending entry, then same-cycle event+ER lands at ptr 0
    do_reset();
    ev(16'hA5A0, 16'hA5A1, 1'b0);
    er_pulse();
    tick(10);
    check("er_cnt",   32'(wcnt[1]), 32'd3);
    check("er_w0",    wlog[1][0], 32'h0000_A5A0);
    check("er_w1",    wlog[1][1], 32'h0001_A5A1);
    check("er_w2",    wlog[1][2], 32'h0002_0001);
    check("er_flush", 32'(flsh[1]), 32'h1);
    ack_pulse();
    tick(1);
    check("er_unflush", 32'(flsh[1]), 32'h0);
    ev(16'hB0B0, 16'hB0B1, 1'b1);
    tick(10);
    check("er2_cnt",   32'(wcnt[1]), 32'd6);
    check("er2_w3",    wlog[1][3], 32'h0000_B0B0);
    check("er2_w5",    wlog[1][5], 32'h0002_0001);
    check("er2_flush", 32'(flsh[1]), 32'h1);

    // Reset asserted mid-W_DST
    do_reset();
    ev(16'h1110, 16'h1111, 1'b0);
    ev(16'h2220, 16'h2221, 1'b0);
    tick(1);
    check("mid_src", {ptr[1], data[1]}, 32'h0000_1110);
    tick(1);
    check("mid_dst_wen", 32'(wen[1]), 32'h1);
    check("mid_dst",     {ptr[1], data[1]}, 32'h0001_1111);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wen",  32'(wen[1]),  32'h0);
    check("mid_rst_data", 32'(data[1]), 32'h0);
    check("mid_rst_ptr",  32'(ptr[1]),  32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("mid_no_rewrite", 32'(wen[1]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cflow_log_writer.md
Name: cflow_log_writer

Overview:
- Parametrised successor to the single-mode CFLog path.
- Takes control-flow transfer events (src/dest pairs from the loop/branch monitors) and writes them into the CFLog memory, one 16-bit word per cycle.
- Modes: plain (2-word entries) or loop-compressed (3-word entries: src, dest, repeat count).
- Requests a TCB flush on high watermark or ER completion, with a flush_ack handshake and a one-entry buffer so events are not lost while a flush is pending.

Parameters:
- LOG_SIZE, 16'h0080: log depth in 16-bit words.
- PTR_W, 16: width of log_ptr.
- LOOP_COMPRESS, 1: 1 = 3-word compressed entries; 0 = 2-word entries.
- CNT_W, 16: repeat-counter width (≤16); saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- branch_detect  input  1  one-cycle pulse: a transfer occurred; cflow_src/cflow_dest valid this cycle
- cflow_src  input  16  transfer source address
- cflow_dest  input  16  transfer destination address
- ER_done  input  1  pulse: ER exit reached; commit everything and flush
- flush_ack  input  1  pulse from TCB: log has been consumed
- log_wen  output  1  write strobe, one word per asserted cycle
- log_ptr  output  PTR_W  word index of the current write
- log_data  output  16  word being written
- flush  output  1  flush request, held until flush_ack
- overrun  output  1  sticky: an event was dropped; cleared only by reset

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM=IDLE; ptr=0; pending/commit registers invalid; count=0.
- Entry size E: 3 when LOOP_COMPRESS=1, else 2.
- Pending register (compress mode only):
  - If branch_detect, pending is valid, the pair equals pending, and count < max: count++ and nothing is written.
  - Otherwise pending moves to the commit register, and the new pair becomes pending with count=1.
- Plain mode: each event goes straight to the commit register.
- Commit register: holds exactly one entry.
  - If a new commit is needed while the commit register is still full, the incoming event is dropped and overrun is set.
  - In compress mode, pending is left unchanged on a drop.
- FSM states: IDLE, W_SRC, W_DST, W_CNT, FLUSH, FLUSH_WAIT.
  - IDLE → W_SRC: commit valid and ptr+E ≤ LOG_SIZE.
  - IDLE → FLUSH: commit valid and ptr+E > LOG_SIZE.
  - W_SRC → W_DST: unconditional.
  - W_DST → W_CNT if compress, else → IDLE.
  - W_CNT → IDLE: unconditional.
  - W_SRC/W_DST/W_CNT each drive log_wen=1, log_data=src/dest/count zero-extended, log_ptr=ptr; ptr++ on that cycle.
  - The commit register is freed in the last write state of the entry.
  - FLUSH: assert flush (registered, rises the cycle after entering) → FLUSH_WAIT.
  - FLUSH_WAIT: hold flush=1; on flush_ack go to IDLE with flush=0 and ptr=0.
- Watermark latency: with watermark hit, the entry is written after the ack, starting at ptr 0.
- ER_done:
  - Latched as er_req.
  - In compress mode, pending moves to commit once the commit register is free.
  - After the commit drains, go to FLUSH even if the log is not full. er_req clears on flush_ack.
  - ER_done with nothing logged still performs a flush with ptr=0.
- Simultaneous events:
  - flush_ack outside FLUSH_WAIT is ignored.
  - branch_detect during FLUSH/FLUSH_WAIT is accepted into pending/commit as normal.
  - ER_done and branch_detect in the same cycle: the event is processed first, then it is included in the flush.
- Latency: an event committed in cycle N with FSM idle writes its src in N+1 and dest in N+2, plus count in N+3 in compress mode.
- Reset mid-entry abandons the partial entry; memory is not rewritten.

Test Plan:
- Plain mode, events (E000→E010) then (E020→E030) 4 cycles apart → words E000,E010,E020,E030 at ptr 0..3, one log_wen each, overrun=0.
- Compress mode, 5 identical (E100→E0F0) pulses then (E200→E300) → ptr0..2 = E100,E0F0,0005 written after the 6th pulse; the new pair stays pending.
- CNT_W=2, 4 identical pulses → entry with count 3 committed, new pending count=1.
- LOG_SIZE=6, compress, 3 distinct committed entries → third entry triggers flush; no write until flush_ack; the entry then lands at ptr 0..2.
- Three distinct events on consecutive cycles, compress mode → third commit attempt while commit full is dropped, overrun=1 stays set.
- ER_done with one pending entry → 3 words written, then flush=1; flush_ack → flush=0, ptr=0; reset_n low mid-W_DST → outputs 0 immediately.
